// File: rtl/urt_rx_frame_parser.sv
// UART command-frame parser: pops RX FIFO bytes, frames SYNC0 SYNC1 TYPE ADDR D[DB-1..0] CHK,
// latency: read/write pulses are registered one cycle after the CHK byte is seen,
// backpressure: pops only when rdy & !empty, at most one byte per two cycles; no output stall.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   o_urtrx_rd_en       FIFO pop; i_urtrx_rd_dat is valid the following cycle
//   i_urtrx_empty/rdy   FIFO empty flag and UART RX ready
//   o_rd_req            one-hot read-request pulse, bit ch*N_PAR+idx
//   o_set_sel, o_wr_stb one-hot write-select and write strobe pulses
//   o_wr_ch/idx/dat     address and data of the last accepted write (held)
//   o_frm_cnt, o_err_*  saturating accept / checksum / timeout / address counters
module urt_rx_frame_parser #(
  parameter int          N_CH    = 2,
  parameter int          N_PAR   = 12,
  parameter int          DW      = 32,
  parameter logic [7:0]  SYNC0   = 8'hEB,
  parameter logic [7:0]  SYNC1   = 8'h90,
  parameter logic [7:0]  TYPE_RD = 8'hA0,
  parameter logic [7:0]  TYPE_WR = 8'hA1,
  parameter int          TMO_CYC = 100000,
  parameter bit          CHK_EN  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   o_urtrx_rd_en,
  input  logic [7:0]             i_urtrx_rd_dat,
  input  logic                   i_urtrx_empty,
  input  logic                   i_urtrx_rdy,
  output logic [N_CH*N_PAR-1:0]  o_rd_req,
  output logic [N_CH*N_PAR-1:0]  o_set_sel,
  output logic                   o_wr_stb,
  output logic [3:0]             o_wr_ch,
  output logic [3:0]             o_wr_idx,
  output logic [DW-1:0]          o_wr_dat,
  output logic [15:0]            o_frm_cnt,
  output logic [15:0]            o_err_chk,
  output logic [15:0]            o_err_tmo,
  output logic [15:0]            o_err_adr
);

  localparam int NW = N_CH * N_PAR;
  localparam int DB = DW / 8;
  localparam int TW = $clog2(TMO_CYC + 1);

  typedef enum logic [2:0] {
    S_HUNT0, S_HUNT1, S_TYPE, S_ADDR, S_DATA, S_CHK
  } state_t;

  state_t          state, state_nxt;
  logic            byte_vld;
  logic            is_wr;
  logic [3:0]      ch, idx;
  logic [1:0]      bcnt;
  logic [DW-1:0]   dat_sr;
  logic [7:0]      sum;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic            ev_rd, ev_wr, ev_chk, ev_adr, ev_tmo;
  logic [8:0]      sel_num;
  logic [NW-1:0]   sel_oh;
  logic            adr_bad;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign sel_num = 9'(int'(ch) * N_PAR + int'(idx));
  assign sel_oh  = NW'(1) << sel_num;
  assign adr_bad = (int'(ch) >= N_CH) || (int'(idx) >= N_PAR);

  // A byte arriving on the terminal count cycle takes priority over the timeout.
  assign tmo_hit = (state != S_HUNT0) && !byte_vld && (tmo_cnt == TW'(TMO_CYC - 1));

  always_comb begin
    state_nxt = state;
    ev_rd     = 1'b0;
    ev_wr     = 1'b0;
    ev_chk    = 1'b0;
    ev_adr    = 1'b0;
    ev_tmo    = 1'b0;
    if (byte_vld) begin
      case (state)
        S_HUNT0: if (i_urtrx_rd_dat == SYNC0) state_nxt = S_HUNT1;
        S_HUNT1: begin
          if (i_urtrx_rd_dat == SYNC1)      state_nxt = S_TYPE;
          else if (i_urtrx_rd_dat == SYNC0) state_nxt = S_HUNT1;
          else                              state_nxt = S_HUNT0;
        end
        S_TYPE: begin
          if (i_urtrx_rd_dat == TYPE_RD || i_urtrx_rd_dat == TYPE_WR) begin
            state_nxt = S_ADDR;
          end else begin
            ev_adr    = 1'b1;
            state_nxt = S_HUNT0;
          end
        end
        S_ADDR: state_nxt = S_DATA;
        S_DATA: if (bcnt == 2'd0) state_nxt = S_CHK;
        S_CHK: begin
          state_nxt = S_HUNT0;
          if (CHK_EN && (i_urtrx_rd_dat != sum)) ev_chk = 1'b1;
          else if (adr_bad)                      ev_adr = 1'b1;
          else if (is_wr)                        ev_wr  = 1'b1;
          else                                   ev_rd  = 1'b1;
        end
        default: state_nxt = S_HUNT0;
      endcase
    end else if (tmo_hit) begin
      ev_tmo    = 1'b1;
      state_nxt = S_HUNT0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_HUNT0;
      o_urtrx_rd_en <= 1'b0;
      byte_vld      <= 1'b0;
      is_wr         <= 1'b0;
      ch            <= '0;
      idx           <= '0;
      bcnt          <= '0;
      dat_sr        <= '0;
      sum           <= '0;
      tmo_cnt       <= '0;
      o_rd_req      <= '0;
      o_set_sel     <= '0;
      o_wr_stb      <= 1'b0;
      o_wr_ch       <= '0;
      o_wr_idx      <= '0;
      o_wr_dat      <= '0;
      o_frm_cnt     <= '0;
      o_err_chk     <= '0;
      o_err_tmo     <= '0;
      o_err_adr     <= '0;
    end else begin
      state         <= state_nxt;
      o_urtrx_rd_en <= i_urtrx_rdy & ~i_urtrx_empty & ~o_urtrx_rd_en;
      byte_vld      <= o_urtrx_rd_en;

      if (state == S_HUNT0 || byte_vld || tmo_hit) tmo_cnt <= '0;
      else                                         tmo_cnt <= tmo_cnt + 1'b1;

      if (byte_vld) begin
        case (state)
          S_TYPE: begin
            is_wr <= (i_urtrx_rd_dat == TYPE_WR);
            sum   <= i_urtrx_rd_dat;
          end
          S_ADDR: begin
            ch   <= i_urtrx_rd_dat[7:4];
            idx  <= i_urtrx_rd_dat[3:0];
            bcnt <= 2'(DB - 1);
            sum  <= sum + i_urtrx_rd_dat;
          end
          S_DATA: begin
            dat_sr <= (dat_sr << 8) | DW'(i_urtrx_rd_dat);
            sum    <= sum + i_urtrx_rd_dat;
            bcnt   <= bcnt - 2'd1;
          end
          default: ;
        endcase
      end

      o_rd_req  <= ev_rd ? sel_oh : '0;
      o_set_sel <= ev_wr ? sel_oh : '0;
      o_wr_stb  <= ev_wr;
      if (ev_wr) begin
        o_wr_ch  <= ch;
        o_wr_idx <= idx;
        o_wr_dat <= dat_sr;
      end

      if (ev_rd || ev_wr) o_frm_cnt <= sat_inc(o_frm_cnt);
      if (ev_chk)         o_err_chk <= sat_inc(o_err_chk);
      if (ev_tmo)         o_err_tmo <= sat_inc(o_err_tmo);
      if (ev_adr)         o_err_adr <= sat_inc(o_err_adr);
    end
  end

endmodule

// File: tb/tb_urt_rx_frame_parser.sv
// Bench for urt_rx_frame_parser: directed frames plus randomized frame streams with random
// FIFO-ready gaps, checked against a frame-level reference model (expected pulse queue and
// expected counter values).
module tb_urt_rx_frame_parser;

  localparam int N_CH  = 2;
  localparam int N_PAR = 12;
  localparam int DW    = 32;
  localparam int TMO   = 64;
  localparam int NW    = N_CH * N_PAR;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rd_en;
  logic [7:0]      rd_dat = 8'h00;
  logic            empty = 1'b1;
  logic            rdy = 1'b1;
  logic [NW-1:0]   rd_req, set_sel;
  logic            wr_stb;
  logic [3:0]      wr_ch, wr_idx;
  logic [DW-1:0]   wr_dat;
  logic [15:0]     frm_cnt, err_chk, err_tmo, err_adr;

  always #5 clk = ~clk;

  urt_rx_frame_parser #(
    .N_CH(N_CH), .N_PAR(N_PAR), .DW(DW), .TMO_CYC(TMO), .CHK_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .o_urtrx_rd_en(rd_en), .i_urtrx_rd_dat(rd_dat),
    .i_urtrx_empty(empty), .i_urtrx_rdy(rdy),
    .o_rd_req(rd_req), .o_set_sel(set_sel), .o_wr_stb(wr_stb),
    .o_wr_ch(wr_ch), .o_wr_idx(wr_idx), .o_wr_dat(wr_dat),
    .o_frm_cnt(frm_cnt), .o_err_chk(err_chk), .o_err_tmo(err_tmo), .o_err_adr(err_adr)
  );

  // ---------------- FIFO model ----------------
  logic [7:0] fifo_q[$];
  bit         rnd_rdy = 1'b0;
  int         cyc = 0;
  int         last_pop = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en && fifo_q.size() > 0) begin
      rd_dat   <= fifo_q.pop_front();
      last_pop <= cyc;
    end
  end

  always @(negedge clk) begin
    empty = (fifo_q.size() == 0);
    rdy   = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          wr;
    int          ch;
    int          idx;
    logic [31:0] dat;
  } ev_t;

  ev_t         exp_q[$];
  int          m_frm = 0, m_chk = 0, m_tmo = 0, m_adr = 0;
  int          lw_ch = 0, lw_idx = 0;
  logic [31:0] lw_dat = '0;

  task automatic expect_ev(input bit wr, input int c, input int i, input logic [31:0] d);
    ev_t e;
    e.wr = wr; e.ch = c; e.idx = i; e.dat = d;
    exp_q.push_back(e);
    m_frm++;
  endtask

  task automatic push_vec(input logic [79:0] v, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(v[8*(n-1-i) +: 8]);
  endtask

  // Builds one frame from its fields and predicts its outcome from the framing rules.
  task automatic send_frame(input logic [7:0] typ, input logic [7:0] adr,
                            input logic [31:0] d, input bit bad_chk);
    int s;
    int c, i;
    c = int'(adr[7:4]);
    i = int'(adr[3:0]);
    fifo_q.push_back(8'hEB);
    fifo_q.push_back(8'h90);
    fifo_q.push_back(typ);
    if (typ != 8'hA0 && typ != 8'hA1) begin
      m_adr++;
      return;
    end
    s = int'(typ) + int'(adr) + int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0]);
    if (bad_chk) s = s + 1 + $urandom_range(0, 254);
    fifo_q.push_back(adr);
    fifo_q.push_back(d[31:24]);
    fifo_q.push_back(d[23:16]);
    fifo_q.push_back(d[15:8]);
    fifo_q.push_back(d[7:0]);
    fifo_q.push_back(8'(s % 256));
    if (bad_chk)                  m_chk++;
    else if (c >= N_CH || i >= N_PAR) m_adr++;
    else                          expect_ev(typ == 8'hA1, c, i, d);
  endtask

  // ---------------- output monitor ----------------
  ev_t           cur;
  logic [NW-1:0] sel;

  always @(negedge clk) begin
    if (!rst && (wr_stb || rd_req != '0 || set_sel != '0)) begin
      check("pulse_latency", 64'(cyc - last_pop), 64'd2);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 64'(rd_req | set_sel), 64'd0);
      end else begin
        cur = exp_q.pop_front();
        sel = NW'(1) << (cur.ch * N_PAR + cur.idx);
        check("wr_stb", 64'(wr_stb), 64'(cur.wr));
        if (cur.wr) begin
          check("set_sel", 64'(set_sel), 64'(sel));
          check("rd_req_idle", 64'(rd_req), 64'd0);
          check("wr_ch", 64'(wr_ch), 64'(cur.ch));
          check("wr_idx", 64'(wr_idx), 64'(cur.idx));
          check("wr_dat", 64'(wr_dat), 64'(cur.dat));
          lw_ch = cur.ch; lw_idx = cur.idx; lw_dat = cur.dat;
        end else begin
          check("rd_req", 64'(rd_req), 64'(sel));
          check("set_sel_idle", 64'(set_sel), 64'd0);
          check("wr_ch_hold", 64'(wr_ch), 64'(lw_ch));
          check("wr_idx_hold", 64'(wr_idx), 64'(lw_idx));
          check("wr_dat_hold", 64'(wr_dat), 64'(lw_dat));
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check_counters(input string tag);
    check({tag, "_frm_cnt"}, 64'(frm_cnt), 64'(m_frm));
    check({tag, "_err_chk"}, 64'(err_chk), 64'(m_chk));
    check({tag, "_err_tmo"}, 64'(err_tmo), 64'(m_tmo));
    check({tag, "_err_adr"}, 64'(err_adr), 64'(m_adr));
  endtask

  task automatic wait_fifo_empty(input string tag);
    for (int i = 0; i < 5000 && fifo_q.size() > 0; i++) @(posedge clk);
    check({tag, "_drain_timeout"}, 64'(fifo_q.size()), 64'd0);
  endtask

  task automatic drain(input string tag);
    wait_fifo_empty(tag);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check({tag, "_missing_pulses"}, 64'(exp_q.size()), 64'd0);
    check_counters(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    check({tag, "_rd_req"}, 64'(rd_req), 64'd0);
    check({tag, "_set_sel"}, 64'(set_sel), 64'd0);
    check({tag, "_wr_stb"}, 64'(wr_stb), 64'd0);
    check({tag, "_wr_ch"}, 64'(wr_ch), 64'd0);
    check({tag, "_wr_idx"}, 64'(wr_idx), 64'd0);
    check({tag, "_wr_dat"}, 64'(wr_dat), 64'd0);
    check({tag, "_frm_cnt"}, 64'(frm_cnt), 64'd0);
    check({tag, "_err_chk"}, 64'(err_chk), 64'd0);
    check({tag, "_err_tmo"}, 64'(err_tmo), 64'd0);
    check({tag, "_err_adr"}, 64'(err_adr), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  typ, adr;
    int          kind;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Write ch1 idx3, then a read of ch0 idx2 that must leave the write registers alone.
    push_vec(80'hEB90A11312345678C8, 9);
    expect_ev(1'b1, 1, 3, 32'h12345678);
    drain("wr_basic");
    push_vec(80'hEB90A002FFFFFFFF9E, 9);
    expect_ev(1'b0, 0, 2, 32'h0);
    drain("rd_basic");

    // Bad checksum followed by a good frame with no gap.
    push_vec(80'hEB90A11312345678C9, 9);
    m_chk++;
    send_frame(8'hA1, 8'h05, 32'hCAFEF00D, 1'b0);
    drain("chk_err");

    // Stalled partial frame: no timeout well before TMO idle cycles, one after.
    push_vec(80'hEB90A11312, 5);
    wait_fifo_empty("tmo_partial");
    repeat (TMO - 20) @(posedge clk);
    @(negedge clk);
    check("tmo_early", 64'(err_tmo), 64'(m_tmo));
    repeat (40) @(posedge clk);
    m_tmo++;
    drain("tmo");
    send_frame(8'hA1, 8'h1B, 32'h0BADBEEF, 1'b0);
    drain("tmo_recover");

    // Resync on a repeated SYNC0, then an out-of-range channel.
    fifo_q.push_back(8'hEB);
    push_vec(80'hEB90A11312345678C8, 9);
    expect_ev(1'b1, 1, 3, 32'h12345678);
    drain("resync");
    push_vec(80'hEB90A12000000001C2, 9);
    m_adr++;
    drain("adr_err");

    // Randomized frame stream with random ready gaps.
    rnd_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      adr  = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 13))};
      typ  = (kind < 4) ? 8'hA0 : 8'hA1;
      if (kind == 8) typ = 8'($urandom_range(0, 159));
      send_frame(typ, adr, $urandom, kind == 9);
    end
    drain("random");
    rnd_rdy = 1'b0;

    // Reset in the middle of a frame discards it and clears everything.
    push_vec(80'hEB90A113, 4);
    wait_fifo_empty("mid_rst");
    repeat (4) @(posedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("mid_reset");
    m_frm = 0; m_chk = 0; m_tmo = 0; m_adr = 0;
    lw_ch = 0; lw_idx = 0; lw_dat = '0;
    rst = 1'b0;
    send_frame(8'hA1, 8'h00, 32'h89ABCDEF, 1'b0);
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
